// File: rtl/control.sv
// rtl/control.sv - multicycle RV32I control FSM: datapath selects, load enables and memory handshake
// Moore outputs come from the state; the Mealy terms are br_en, mem_offset, funct3/funct7 and opcode in DECODE.
module control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       br_en,
   input  logic [1:0] mem_offset,
   input  logic       mem_resp,
   output logic [1:0] pcmux_sel,
   output logic       alumux1_sel,
   output logic [2:0] alumux2_sel,
   output logic [3:0] regfilemux_sel,
   output logic       marmux_sel,
   output logic       cmpmux_sel,
   output logic [2:0] aluop,
   output logic [2:0] cmpop,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_regfile,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_data_out,
   output logic       mem_read,
   output logic       mem_write,
   output logic [3:0] mem_byte_enable
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_SR   = 3'd5;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SRA = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;

   localparam logic [2:0] CMP_BLT  = 3'd4;
   localparam logic [2:0] CMP_BLTU = 3'd6;

   typedef enum logic [3:0] {
      FETCH1, FETCH2, FETCH3, DECODE,
      IMM, REG, LUI, AUIPC, BR, JAL, JALR,
      CALC_ADDR, LD1, LD2, ST1, ST2
   } state_t;

   state_t state, state_next;

   logic alt;
   logic unused_funct7;
   assign alt           = funct7[5];
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH1;
      else     state <= state_next;
   end

   always_comb begin
      state_next      = state;
      pcmux_sel       = 2'd0;
      alumux1_sel     = 1'b0;
      alumux2_sel     = 3'd0;
      regfilemux_sel  = 4'd0;
      marmux_sel      = 1'b0;
      cmpmux_sel      = 1'b0;
      aluop           = funct3;
      cmpop           = funct3;
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_data_out   = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 4'b1111;

      // Outputs stay at defaults while reset is held so a pending request drops at once.
      if (!rst) begin
         case (state)
            FETCH1: begin
               load_mar   = 1'b1;
               state_next = FETCH2;
            end
            FETCH2: begin
               mem_read = 1'b1;
               load_mdr = 1'b1;
               if (mem_resp) state_next = FETCH3;
            end
            FETCH3: begin
               load_ir    = 1'b1;
               state_next = DECODE;
            end
            DECODE: begin
               case (opcode)
                  OP_IMM:   state_next = IMM;
                  OP_REG:   state_next = REG;
                  OP_LUI:   state_next = LUI;
                  OP_AUIPC: state_next = AUIPC;
                  OP_BR:    state_next = BR;
                  OP_JAL:   state_next = JAL;
                  OP_JALR:  state_next = JALR;
                  OP_LOAD,
                  OP_STORE: state_next = CALC_ADDR;
                  default: begin
                     load_pc    = 1'b1;
                     state_next = FETCH1;
                  end
               endcase
            end
            IMM: begin
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                  cmpmux_sel     = 1'b1;
                  cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                  regfilemux_sel = 4'd1;
               end else if (funct3 == F3_SR && alt) begin
                  aluop = ALU_SRA;
               end
               state_next = FETCH1;
            end
            REG: begin
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               alumux2_sel  = 3'd5;
               if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                  cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                  regfilemux_sel = 4'd1;
               end else if (funct3 == F3_ADD && alt) begin
                  aluop = ALU_SUB;
               end else if (funct3 == F3_SR && alt) begin
                  aluop = ALU_SRA;
               end
               state_next = FETCH1;
            end
            LUI: begin
               regfilemux_sel = 4'd2;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               state_next     = FETCH1;
            end
            AUIPC: begin
               alumux1_sel  = 1'b1;
               alumux2_sel  = 3'd1;
               aluop        = ALU_ADD;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_next   = FETCH1;
            end
            BR: begin
               alumux1_sel = 1'b1;
               alumux2_sel = 3'd2;
               aluop       = ALU_ADD;
               pcmux_sel   = br_en ? 2'd1 : 2'd0;
               load_pc     = 1'b1;
               state_next  = FETCH1;
            end
            JAL: begin
               regfilemux_sel = 4'd4;
               load_regfile   = 1'b1;
               alumux1_sel    = 1'b1;
               alumux2_sel    = 3'd4;
               aluop          = ALU_ADD;
               pcmux_sel      = 2'd1;
               load_pc        = 1'b1;
               state_next     = FETCH1;
            end
            JALR: begin
               // pc_plus4 is still the old PC here; regfile and PC load on the same edge.
               regfilemux_sel = 4'd4;
               load_regfile   = 1'b1;
               aluop          = ALU_ADD;
               pcmux_sel      = 2'd2;
               load_pc        = 1'b1;
               state_next     = FETCH1;
            end
            CALC_ADDR: begin
               aluop      = ALU_ADD;
               marmux_sel = 1'b1;
               load_mar   = 1'b1;
               if (opcode == OP_STORE) begin
                  alumux2_sel   = 3'd3;
                  load_data_out = 1'b1;
                  state_next    = ST1;
               end else begin
                  state_next = LD1;
               end
            end
            LD1: begin
               mem_read = 1'b1;
               load_mdr = 1'b1;
               aluop    = ALU_ADD;
               if (mem_resp) state_next = LD2;
            end
            LD2: begin
               aluop        = ALU_ADD;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               case (funct3)
                  3'd0:    regfilemux_sel = 4'd5;
                  3'd1:    regfilemux_sel = 4'd7;
                  3'd4:    regfilemux_sel = 4'd6;
                  3'd5:    regfilemux_sel = 4'd8;
                  default: regfilemux_sel = 4'd3;
               endcase
               state_next = FETCH1;
            end
            ST1: begin
               mem_write   = 1'b1;
               alumux2_sel = 3'd3;
               aluop       = ALU_ADD;
               case (funct3)
                  3'd0:    mem_byte_enable = 4'b0001 << mem_offset;
                  3'd1:    mem_byte_enable = 4'b0011 << mem_offset;
                  default: mem_byte_enable = 4'b1111;
               endcase
               if (mem_resp) state_next = ST2;
            end
            ST2: begin
               load_pc    = 1'b1;
               state_next = FETCH1;
            end
            default: state_next = FETCH1;
         endcase
      end
   end

endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - directed self-checking bench for the control FSM
module tb_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       br_en;
   logic [1:0] mem_offset;
   logic       mem_resp;
   logic [1:0] pcmux_sel;
   logic       alumux1_sel;
   logic [2:0] alumux2_sel;
   logic [3:0] regfilemux_sel;
   logic       marmux_sel;
   logic       cmpmux_sel;
   logic [2:0] aluop;
   logic [2:0] cmpop;
   logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
   logic       mem_read, mem_write;
   logic [3:0] mem_byte_enable;

   int n_cmp = 0;
   int n_err = 0;

   control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .br_en(br_en), .mem_offset(mem_offset), .mem_resp(mem_resp),
      .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
      .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
      .aluop(aluop), .cmpop(cmpop), .load_pc(load_pc), .load_ir(load_ir),
      .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
      .load_data_out(load_data_out), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable)
   );

   always #5 clk = ~clk;

   // Advance one state; sampling happens mid low phase, well away from posedge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode = op;
      funct3 = f3;
      funct7 = f7;
   endtask

   // Entered during FETCH1; returns during DECODE.
   task automatic do_fetch(input int lat);
      step();
      n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL fetch2_mem_read got %b exp 1", mem_read); end
      for (int i = 1; i < lat; i++) step();
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      n_cmp++; if (load_ir !== 1'b1) begin n_err++; $display("FAIL fetch3_load_ir got %b exp 1", load_ir); end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (load_mar !== 1'b0) begin n_err++; $display("FAIL reset_held_load_mar got %b exp 0", load_mar); end
      rst = 1'b0;
      #1;
      n_cmp++; if (load_mar !== 1'b1) begin n_err++; $display("FAIL reset_fetch1_load_mar got %b exp 1", load_mar); end
      step();
      n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL reset_fetch2_mem_read got %b exp 1", mem_read); end
      rst = 1'b1;
      #1;
      n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mid_fetch2_mem_read got %b exp 0", mem_read); end
      n_cmp++; if (load_mdr !== 1'b0) begin n_err++; $display("FAIL reset_mid_fetch2_load_mdr got %b exp 0", load_mdr); end
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (load_mar !== 1'b1 || marmux_sel !== 1'b0 || mem_read !== 1'b0) begin
         n_err++; $display("FAIL reset_release_fetch1 got load_mar=%b marmux=%b mem_read=%b exp 1/0/0", load_mar, marmux_sel, mem_read);
      end
   endtask

   task automatic test_addi();
      set_instr(7'b0010011, 3'd0, 7'h00);
      do_fetch(1);
      n_cmp++; if (load_pc !== 1'b0 || load_regfile !== 1'b0) begin
         n_err++; $display("FAIL addi_decode_loads got pc=%b rf=%b exp 0/0", load_pc, load_regfile);
      end
      step();
      n_cmp++; if (aluop !== 3'd0) begin n_err++; $display("FAIL addi_aluop got %0d exp 0", aluop); end
      n_cmp++; if (alumux2_sel !== 3'd0) begin n_err++; $display("FAIL addi_alumux2 got %0d exp 0", alumux2_sel); end
      n_cmp++; if (load_regfile !== 1'b1 || load_pc !== 1'b1 || pcmux_sel !== 2'd0 || regfilemux_sel !== 4'd0) begin
         n_err++; $display("FAIL addi_writeback got rf=%b pc=%b pcmux=%0d rfmux=%0d exp 1/1/0/0", load_regfile, load_pc, pcmux_sel, regfilemux_sel);
      end
      step();
      n_cmp++; if (load_mar !== 1'b1) begin n_err++; $display("FAIL addi_back_to_fetch1 got %b exp 1", load_mar); end
   endtask

   task automatic test_alu_variants();
      set_instr(7'b0110011, 3'd0, 7'h20);
      do_fetch(2);
      step();
      n_cmp++; if (aluop !== 3'd3 || alumux2_sel !== 3'd5 || load_regfile !== 1'b1) begin
         n_err++; $display("FAIL sub got aluop=%0d alumux2=%0d rf=%b exp 3/5/1", aluop, alumux2_sel, load_regfile);
      end
      step();
      set_instr(7'b0010011, 3'd5, 7'h20);
      do_fetch(1);
      step();
      n_cmp++; if (aluop !== 3'd2) begin n_err++; $display("FAIL srai_aluop got %0d exp 2", aluop); end
      step();
      set_instr(7'b0010011, 3'd3, 7'h00);
      do_fetch(1);
      step();
      n_cmp++; if (cmpop !== 3'd6 || cmpmux_sel !== 1'b1 || regfilemux_sel !== 4'd1) begin
         n_err++; $display("FAIL sltiu got cmpop=%0d cmpmux=%b rfmux=%0d exp 6/1/1", cmpop, cmpmux_sel, regfilemux_sel);
      end
      step();
   endtask

   task automatic test_branch();
      for (int b = 1; b >= 0; b--) begin
         set_instr(7'b1100011, 3'd0, 7'h00);
         br_en = b[0];
         do_fetch(1);
         step();
         n_cmp++; if (pcmux_sel !== {1'b0, b[0]}) begin n_err++; $display("FAIL beq_pcmux br_en=%0d got %0d exp %0d", b, pcmux_sel, b); end
         n_cmp++; if (alumux1_sel !== 1'b1 || alumux2_sel !== 3'd2 || load_pc !== 1'b1 || load_regfile !== 1'b0) begin
            n_err++; $display("FAIL beq_sel br_en=%0d got mux1=%b mux2=%0d pc=%b rf=%b exp 1/2/1/0", b, alumux1_sel, alumux2_sel, load_pc, load_regfile);
         end
         step();
      end
      br_en = 1'b0;
   endtask

   task automatic test_store(input logic [2:0] f3, input logic [1:0] off, input int lat, input logic [3:0] exp_be);
      set_instr(7'b0100011, f3, 7'h00);
      mem_offset = off;
      do_fetch(1);
      step();
      n_cmp++; if (marmux_sel !== 1'b1 || load_mar !== 1'b1 || alumux2_sel !== 3'd3 || load_data_out !== 1'b1) begin
         n_err++; $display("FAIL store_calc got marmux=%b mar=%b mux2=%0d dout=%b exp 1/1/3/1", marmux_sel, load_mar, alumux2_sel, load_data_out);
      end
      step();
      for (int i = 0; i < lat; i++) begin
         n_cmp++; if (mem_write !== 1'b1 || mem_byte_enable !== exp_be) begin
            n_err++; $display("FAIL store_st1 f3=%0d cyc=%0d got wr=%b be=%b exp 1/%b", f3, i, mem_write, mem_byte_enable, exp_be);
         end
         if (i == lat - 1) mem_resp = 1'b1;
         step();
         mem_resp = 1'b0;
      end
      n_cmp++; if (load_pc !== 1'b1 || mem_write !== 1'b0) begin
         n_err++; $display("FAIL store_st2 got pc=%b wr=%b exp 1/0", load_pc, mem_write);
      end
      step();
   endtask

   task automatic test_load_jump();
      set_instr(7'b0000011, 3'd4, 7'h00);
      mem_offset = 2'd3;
      do_fetch(1);
      step();
      step();
      n_cmp++; if (mem_read !== 1'b1 || load_mdr !== 1'b1 || aluop !== 3'd0 || alumux2_sel !== 3'd0) begin
         n_err++; $display("FAIL lbu_ld1 got rd=%b mdr=%b aluop=%0d mux2=%0d exp 1/1/0/0", mem_read, load_mdr, aluop, alumux2_sel);
      end
      step();
      n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL lbu_ld1_hold got %b exp 1", mem_read); end
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      n_cmp++; if (regfilemux_sel !== 4'd6 || load_regfile !== 1'b1 || load_pc !== 1'b1) begin
         n_err++; $display("FAIL lbu_ld2 got rfmux=%0d rf=%b pc=%b exp 6/1/1", regfilemux_sel, load_regfile, load_pc);
      end
      step();
      set_instr(7'b1100111, 3'd0, 7'h00);
      do_fetch(1);
      step();
      n_cmp++; if (pcmux_sel !== 2'd2 || regfilemux_sel !== 4'd4 || alumux1_sel !== 1'b0 || alumux2_sel !== 3'd0 || load_regfile !== 1'b1) begin
         n_err++; $display("FAIL jalr got pcmux=%0d rfmux=%0d mux1=%b mux2=%0d rf=%b exp 2/4/0/0/1", pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel, load_regfile);
      end
      step();
      set_instr(7'b1101111, 3'd0, 7'h00);
      do_fetch(1);
      step();
      n_cmp++; if (pcmux_sel !== 2'd1 || alumux1_sel !== 1'b1 || alumux2_sel !== 3'd4 || regfilemux_sel !== 4'd4) begin
         n_err++; $display("FAIL jal got pcmux=%0d mux1=%b mux2=%0d rfmux=%0d exp 1/1/4/4", pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel);
      end
      step();
   endtask

   task automatic test_illegal_and_stray();
      set_instr(7'h7F, 3'd0, 7'h00);
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      step();
      n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL stray_resp_ignored got %b exp 1", mem_read); end
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      step();
      n_cmp++; if (load_pc !== 1'b1 || load_regfile !== 1'b0 || pcmux_sel !== 2'd0) begin
         n_err++; $display("FAIL illegal_decode got pc=%b rf=%b pcmux=%0d exp 1/0/0", load_pc, load_regfile, pcmux_sel);
      end
      step();
      n_cmp++; if (load_mar !== 1'b1) begin n_err++; $display("FAIL illegal_to_fetch1 got %b exp 1", load_mar); end
   endtask

   initial begin
      rst        = 1'b1;
      br_en      = 1'b0;
      mem_offset = 2'd0;
      mem_resp   = 1'b0;
      set_instr(7'b0010011, 3'd0, 7'h00);
      test_reset();
      test_addi();
      test_alu_variants();
      test_branch();
      test_store(3'd0, 2'd2, 3, 4'b0100);
      test_store(3'd1, 2'd2, 1, 4'b1100);
      test_store(3'd2, 2'd0, 2, 4'b1111);
      test_load_jump();
      test_illegal_and_stray();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/control.md
Name: control

Overview:
Multicycle RV32I control unit. It sequences fetch/decode/execute through a Moore/Mealy FSM and drives every select and load-enable of the datapath. It also owns the memory handshake: mem_read, mem_write, byte enables, and waiting on mem_resp. It consumes the decoded instruction fields and br_en from the datapath, and the low address bits of the ALU result.

Parameters:
None.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
opcode  in  7  rv32i_opcode from IR
funct3  in  3  from IR
funct7  in  7  from IR; bit 5 selects sub/sra
br_en  in  1  comparator result
mem_offset  in  2  alu_out[1:0]; byte offset of the load/store address
mem_resp  in  1  memory transaction complete, single-cycle pulse
pcmux_sel  out  2  0 pc_plus4, 1 alu_out, 2 alu_mod2
alumux1_sel  out  1  0 rs1_out, 1 pc_out
alumux2_sel  out  3  0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2_out
regfilemux_sel  out  4  0 alu_out, 1 br_en, 2 u_imm, 3 lw, 4 pc_plus4, 5 lb, 6 lbu, 7 lh, 8 lhu
marmux_sel  out  1  0 pc_out, 1 alu_out
cmpmux_sel  out  1  0 rs2_out, 1 i_imm
aluop  out  3  0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and
cmpop  out  3  branch_funct3_t encoding
load_pc / load_ir / load_regfile / load_mar / load_mdr / load_data_out  out  1 each  register load enables
mem_read  out  1  read request; held until mem_resp
mem_write  out  1  write request; held until mem_resp
mem_byte_enable  out  4  write byte lanes

Behaviour:
- Defaults in every state unless overridden:
  - all loads, mem_read and mem_write = 0
  - all selects = 0
  - aluop = funct3; cmpop = funct3
  - mem_byte_enable = 4'b1111
- Reset: async to FETCH1; all outputs take their defaults immediately, so an in-flight mem_read/mem_write drops the same instant.
- FETCH1: marmux=pc_out, load_mar → FETCH2.
- FETCH2: mem_read, load_mdr; stay until mem_resp → FETCH3.
- FETCH3: load_ir → DECODE.
- DECODE: no outputs. Dispatch on opcode:
  - op_imm→IMM, op_reg→REG, lui→LUI, auipc→AUIPC
  - br→BR, jal→JAL, jalr→JALR
  - load/store→CALC_ADDR
  - any other opcode→FETCH1 with load_pc (pc_plus4); no architectural write
- Every execute-terminal state asserts load_pc (pc_plus4 unless stated otherwise), then → FETCH1.
- IMM: load_regfile, alumux2=i_imm.
  - slti/sltiu: cmpmux=i_imm, cmpop=blt/bltu, regfilemux=br_en.
  - sr with funct7[5]=1: aluop=sra.
- REG: load_regfile, alumux2=rs2_out.
  - add with funct7[5]=1: aluop=sub.
  - sr with funct7[5]=1: aluop=sra.
  - slt/sltu: cmpmux=rs2_out, blt/bltu, regfilemux=br_en.
- LUI: regfilemux=u_imm, load_regfile.
- AUIPC: alumux1=pc_out, alumux2=u_imm, aluop=add, load_regfile.
- BR: alumux1=pc_out, alumux2=b_imm, aluop=add; pcmux = br_en ? alu_out : pc_plus4.
- JAL: regfilemux=pc_plus4, load_regfile; alumux1=pc_out, alumux2=j_imm, add; pcmux=alu_out.
- JALR: same as JAL but alumux1=rs1_out, alumux2=i_imm, pcmux=alu_mod2. Writeback uses the old PC (same-edge load).
- CALC_ADDR: aluop=add, marmux=alu_out, load_mar.
  - load: alumux2=i_imm → LD1.
  - store: alumux2=s_imm, load_data_out → ST1.
- LD1: mem_read, load_mdr; hold alumux2=i_imm/add so mem_offset stays valid; wait for mem_resp → LD2.
- LD2: regfilemux per funct3 (lb/lh/lw/lbu/lhu); load_regfile; same ALU hold.
- ST1: mem_write; alumux2=s_imm/add held; wait for mem_resp → ST2.
  - Byte enables: sw 1111; sh 0011<<mem_offset; sb 0001<<mem_offset.
- ST2: load_pc.
- Memory wait is unbounded: no timeout. A mem_resp outside FETCH2/LD1/ST1 is ignored.

Test Plan:
- Reset asserted mid-FETCH2 with mem_read=1 → mem_read=0 the same cycle; after release, first state FETCH1 with load_mar=1 and marmux=0.
- ADDI x1,x0,5 with 1-cycle mem_resp → FETCH1,FETCH2,FETCH3,DECODE,IMM (5 cycles); IMM: aluop=0, alumux2=0, load_regfile=1, load_pc=1, pcmux=0.
- SUB (funct7=0x20) → REG with aluop=3; SRAI (funct7=0x20) → aluop=2; SLTIU → cmpop=bltu, cmpmux=1, regfilemux=1.
- BEQ, br_en=1 then 0 → pcmux=1 then 0; alumux1=1, alumux2=2 both times.
- SB with mem_offset=2, mem_resp after 3 cycles → ST1 held 3 cycles, mem_byte_enable=0100, mem_write=1; SH offset 2 → 1100.
- LBU offset 3 → LD2 regfilemux=6, load_regfile=1; JALR → pcmux=2, regfilemux=4; opcode 0x7F → DECODE→FETCH1 with load_regfile=0, load_pc=1.
